// File: rtl/bus_pkg.sv
// Shared types for the bus scheduler: dual-rail bit encoding, FSM states and helpers.
// A dual-rail bit is {t, f}. 00 is NULL, 10 is logic 1, 01 is logic 0, and 11 is illegal.
package bus_pkg;

  localparam int SIZE = 4;

  typedef logic [1:0] dual_t;

  localparam dual_t DUAL_NULL = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A dual-rail bit carries a value only when exactly one rail is high.
  function automatic logic dual_valid(input dual_t d);
    return d[1] ^ d[0];
  endfunction

endpackage

// File: rtl/bus_scheduler_if.sv
// User-side request/response signals and the shared dual-rail resource port of bus_scheduler.
interface bus_scheduler_if #(
  parameter int USERS  = 4,
  parameter int INPUT  = bus_pkg::SIZE,
  parameter int OUTPUT = bus_pkg::SIZE
);

  logic [USERS-1:0]                           user_req;
  bus_pkg::dual_t [USERS-1:0][INPUT-1:0]      user_input;
  logic [USERS-1:0]                           user_ack;
  logic [USERS-1:0]                           user_valid;
  bus_pkg::dual_t [OUTPUT-1:0]                user_output;
  logic                                       user_err;
  bus_pkg::dual_t [INPUT-1:0]                 in;
  bus_pkg::dual_t [OUTPUT-1:0]                out;

  // The scheduler side.
  modport slave (
    input  user_req, user_input, out,
    output user_ack, user_valid, user_output, user_err, in
  );

  // Requesters plus the shared resource.
  modport master (
    output user_req, user_input, out,
    input  user_ack, user_valid, user_output, user_err, in
  );

endinterface

// File: rtl/done.sv
// Two-phase completion detect: every dual-rail bit is valid and has changed since the last completion.
module done import bus_pkg::*; #(
  parameter int WIDTH = SIZE
) (
  input  dual_t [WIDTH-1:0] cur,
  input  dual_t [WIDTH-1:0] prev,
  output logic              done_out
);

  logic [WIDTH-1:0] bit_done;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bit_done[gi] = dual_valid(cur[gi]) && (cur[gi] != prev[gi]);
  end

  assign done_out = &bit_done;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter  int USERS = 4,
  localparam int PW    = $clog2(USERS)
) (
  input  logic [USERS-1:0] req,
  input  logic [PW-1:0]    pointer,
  output logic [USERS-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             any
);

  logic [PW:0] pos;

  always_comb begin
    pos = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < USERS; i++) begin
      // One extra bit so pointer + offset never overflows before the wrap.
      pos = {1'b0, pointer} + (PW+1)'(i);
      if (pos >= (PW+1)'(USERS)) begin
        pos = pos - (PW+1)'(USERS);
      end
      if (!any && req[pos[PW-1:0]]) begin
        any = 1'b1;
        idx = pos[PW-1:0];
      end
    end
    gnt = any ? (USERS'(1) << idx) : '0;
  end

endmodule

// File: rtl/bus_scheduler.sv
// Round-robin scheduler sharing one two-phase dual-rail resource among USERS requesters,
// with a completion glitch filter and a timeout watchdog for a stalled resource.
module bus_scheduler import bus_pkg::*; #(
  parameter int USERS   = 4,
  parameter int INPUT   = SIZE,
  parameter int OUTPUT  = SIZE,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  bus_scheduler_if.slave  bus,
  output logic            busy,
  output logic            stray
);

  localparam int PW = $clog2(USERS);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_t                 state_reg, state_next;
  logic [PW-1:0]          ptr_reg, ptr_next;
  logic [PW-1:0]          gnt_reg, gnt_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   err_reg, err_next;
  logic [USERS-1:0]       ack_reg, ack_next;
  logic                   stray_reg, stray_next;
  dual_t [INPUT-1:0]      in_reg, in_next;
  dual_t [OUTPUT-1:0]     result_reg, result_next;
  dual_t [OUTPUT-1:0]     prev_out_reg, prev_out_next;
  dual_t [OUTPUT-1:0]     out_q;

  logic                   done_out;
  logic                   done_q;
  logic                   done_stable;

  logic [USERS-1:0]       arb_gnt;
  logic [PW-1:0]          arb_idx;
  logic                   arb_any;
  logic [USERS-1:0]       valid_vec;

  rr_arbiter #(
    .USERS (USERS)
  ) u_arb (
    .req     (bus.user_req),
    .pointer (ptr_reg),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  done #(
    .WIDTH (OUTPUT)
  ) u_done (
    .cur      (out_q),
    .prev     (prev_out_reg),
    .done_out (done_out)
  );

  // The resource is asynchronous to us; sample it once before any decision.
  always_ff @(posedge clk) begin
    out_q <= bus.out;
  end

  // A completion must persist for two cycles to count, so skewed rail transitions are ignored.
  assign done_stable = done_out && done_q;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    gnt_next      = gnt_reg;
    cnt_next      = cnt_reg;
    err_next      = err_reg;
    in_next       = in_reg;
    result_next   = result_reg;
    prev_out_next = prev_out_reg;
    ack_next      = '0;
    stray_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (done_stable) begin
          stray_next    = 1'b1;
          prev_out_next = out_q;
        end
        if (arb_any) begin
          gnt_next   = arb_idx;
          in_next    = bus.user_input[arb_idx];
          ack_next   = arb_gnt;
          cnt_next   = '0;
          err_next   = 1'b0;
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CW'(1);
        end
        if (done_stable) begin
          result_next   = out_q;
          prev_out_next = out_q;
          err_next      = 1'b0;
          state_next    = RESP;
        end else if (cnt_reg == CNT_MAX) begin
          // Resync the reference so a late completion is not mistaken for the next one.
          err_next      = 1'b1;
          prev_out_next = out_q;
          state_next    = RESP;
        end
      end

      RESP: begin
        ptr_next   = (gnt_reg == PW'(USERS - 1)) ? '0 : gnt_reg + PW'(1);
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      gnt_reg      <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      ack_reg      <= '0;
      stray_reg    <= 1'b0;
      in_reg       <= {INPUT{DUAL_NULL}};
      result_reg   <= {OUTPUT{DUAL_NULL}};
      prev_out_reg <= out_q;
      done_q       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      gnt_reg      <= gnt_next;
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
      ack_reg      <= ack_next;
      stray_reg    <= stray_next;
      in_reg       <= in_next;
      result_reg   <= result_next;
      prev_out_reg <= prev_out_next;
      done_q       <= done_out;
    end
  end

  for (genvar gi = 0; gi < USERS; gi++) begin : g_valid
    assign valid_vec[gi] = (state_reg == RESP) && (gnt_reg == PW'(gi));
  end

  assign bus.user_valid  = valid_vec;
  assign bus.user_ack    = ack_reg;
  assign bus.user_output = result_reg;
  assign bus.user_err    = (state_reg == RESP) && err_reg;
  assign bus.in          = in_reg;
  assign busy            = (state_reg != IDLE);
  assign stray           = stray_reg;

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed self-checking bench for bus_scheduler: single transaction, round-robin order,
// timeout, stray completion, glitch rejection and mid-transaction reset.
module tb_bus_scheduler;

  localparam int USERS = 4;
  localparam int W     = 4;

  logic clk;
  logic reset;
  logic busy;
  logic stray;

  int checks;
  int errors;
  logic [W-1:0] out_val;

  bus_scheduler_if #(.USERS(USERS), .INPUT(W), .OUTPUT(W)) bus ();

  bus_scheduler #(
    .USERS   (USERS),
    .INPUT   (W),
    .OUTPUT  (W),
    .TIMEOUT (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .stray (stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logical nibble -> dual-rail: 1 -> 10, 0 -> 01.
  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic flip_out;
    out_val = ~out_val;
    bus.out = enc(out_val);
  endtask

  task automatic wait_ack(input int limit, output int cyc);
    int i;
    i = 0;
    cyc = -1;
    while (cyc < 0 && i < limit) begin
      i++;
      @(negedge clk);
      if (bus.user_ack != '0) cyc = i;
    end
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    int i;
    i = 0;
    cyc = -1;
    while (cyc < 0 && i < limit) begin
      i++;
      @(negedge clk);
      if (bus.user_valid != '0) cyc = i;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (bus.in !== '0) begin errors++; $display("FAIL reset_in got %h want 00", bus.in); end
    checks++;
    if (bus.user_output !== '0) begin errors++; $display("FAIL reset_output got %h want 00", bus.user_output); end
    checks++;
    if ({bus.user_ack, bus.user_valid, bus.user_err, stray} !== '0) begin
      errors++;
      $display("FAIL reset_flags got ack=%b valid=%b err=%b stray=%b want 0", bus.user_ack, bus.user_valid, bus.user_err, stray);
    end
    $display("test_reset done");
  endtask

  task automatic test_single;
    int cyc;
    bus.user_input[1] = enc(4'hA);
    bus.user_req      = 4'b0010;
    wait_ack(10, cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL t1_ack_latency got %0d want 1", cyc); end
    checks++;
    if (bus.user_ack !== 4'b0010) begin errors++; $display("FAIL t1_ack got %b want 0010", bus.user_ack); end
    checks++;
    if (bus.in !== enc(4'hA)) begin errors++; $display("FAIL t1_in got %h want %h", bus.in, enc(4'hA)); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b want 1", busy); end
    @(negedge clk);
    bus.user_req = '0;
    checks++;
    if (bus.user_ack !== 4'b0000) begin errors++; $display("FAIL t1_ack_pulse got %b want 0000", bus.user_ack); end
    repeat (4) @(negedge clk);
    flip_out();
    wait_valid(20, cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL t1_valid_latency got %0d want 3", cyc); end
    checks++;
    if (bus.user_valid !== 4'b0010) begin errors++; $display("FAIL t1_valid got %b want 0010", bus.user_valid); end
    checks++;
    if (bus.user_output !== enc(4'hF)) begin errors++; $display("FAIL t1_output got %h want %h", bus.user_output, enc(4'hF)); end
    checks++;
    if (bus.user_err !== 1'b0) begin errors++; $display("FAIL t1_err got %b want 0", bus.user_err); end
    @(negedge clk);
    checks++;
    if ({busy, bus.user_valid} !== 5'b0) begin errors++; $display("FAIL t1_back_idle got busy=%b valid=%b want 0", busy, bus.user_valid); end
    checks++;
    if (bus.in !== enc(4'hA)) begin errors++; $display("FAIL t1_in_hold got %h want %h", bus.in, enc(4'hA)); end
    $display("test_single done");
  endtask

  task automatic test_round_robin;
    int cyc;
    logic [W-1:0] pay [USERS];
    logic [USERS-1:0] exp_oh;
    pay[0] = 4'h1; pay[1] = 4'h4; pay[2] = 4'h7; pay[3] = 4'hA;
    do_reset();
    for (int u = 0; u < USERS; u++) bus.user_input[u] = enc(pay[u]);
    bus.user_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << (k % USERS);
      wait_ack(10, cyc);
      checks++;
      if (bus.user_ack !== exp_oh) begin errors++; $display("FAIL t2_grant%0d got %b want %b", k, bus.user_ack, exp_oh); end
      checks++;
      if (bus.in !== enc(pay[k % USERS])) begin errors++; $display("FAIL t2_in%0d got %h want %h", k, bus.in, enc(pay[k % USERS])); end
      if (k == 4) bus.user_req = '0;
      @(negedge clk);
      checks++;
      if (bus.user_ack !== 4'b0000) begin errors++; $display("FAIL t2_ack_once%0d got %b want 0000", k, bus.user_ack); end
      flip_out();
      wait_valid(20, cyc);
      checks++;
      if (bus.user_valid !== exp_oh || cyc !== 3) begin
        errors++;
        $display("FAIL t2_valid%0d got %b after %0d want %b after 3", k, bus.user_valid, cyc, exp_oh);
      end
      checks++;
      if (bus.user_output !== enc(out_val)) begin errors++; $display("FAIL t2_output%0d got %h want %h", k, bus.user_output, enc(out_val)); end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_timeout;
    int cyc;
    bus.user_input[2] = enc(4'h3);
    bus.user_req = 4'b0100;
    wait_ack(10, cyc);
    checks++;
    if (bus.user_ack !== 4'b0100) begin errors++; $display("FAIL t3_ack got %b want 0100", bus.user_ack); end
    bus.user_req = '0;
    wait_valid(400, cyc);
    checks++;
    if (cyc !== 256) begin errors++; $display("FAIL t3_timeout_cycles got %0d want 256", cyc); end
    checks++;
    if (bus.user_valid !== 4'b0100) begin errors++; $display("FAIL t3_valid got %b want 0100", bus.user_valid); end
    checks++;
    if (bus.user_err !== 1'b1) begin errors++; $display("FAIL t3_err got %b want 1", bus.user_err); end
    @(negedge clk);
    checks++;
    if ({busy, bus.user_valid, bus.user_err} !== 6'b0) begin
      errors++;
      $display("FAIL t3_idle got busy=%b valid=%b err=%b want 0", busy, bus.user_valid, bus.user_err);
    end
    $display("test_timeout done");
  endtask

  task automatic test_stray;
    int cyc;
    int bad;
    flip_out();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (stray !== (i == 3)) begin errors++; $display("FAIL t4_stray_c%0d got %b want %b", i, stray, (i == 3)); end
    end
    bus.user_input[3] = enc(4'h9);
    bus.user_req = 4'b1000;
    wait_ack(10, cyc);
    checks++;
    if (bus.user_ack !== 4'b1000) begin errors++; $display("FAIL t4_ack got %b want 1000", bus.user_ack); end
    bus.user_req = '0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.user_valid !== 4'b0000) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL t4_false_done got %0d valid cycles want 0", bad); end
    flip_out();
    wait_valid(20, cyc);
    checks++;
    if (bus.user_valid !== 4'b1000 || cyc !== 3) begin errors++; $display("FAIL t4_valid got %b after %0d want 1000 after 3", bus.user_valid, cyc); end
    checks++;
    if (bus.user_output !== enc(out_val)) begin errors++; $display("FAIL t4_output got %h want %h", bus.user_output, enc(out_val)); end
    $display("test_stray done");
  endtask

  task automatic test_glitch;
    int cyc;
    int bad;
    bus.user_input[0] = enc(4'h6);
    bus.user_req = 4'b0001;
    wait_ack(10, cyc);
    checks++;
    if (bus.user_ack !== 4'b0001) begin errors++; $display("FAIL t5_ack got %b want 0001", bus.user_ack); end
    bus.user_req = '0;
    @(negedge clk);
    bus.out[1:0] = ~bus.out[1:0];
    @(negedge clk);
    bus.out = enc(out_val);
    @(negedge clk);
    bus.out = enc(~out_val);
    @(negedge clk);
    bus.out = enc(out_val);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.user_valid !== 4'b0000) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL t5_glitch_done got %0d valid cycles want 0", bad); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t5_still_wait got busy=%b want 1", busy); end
    flip_out();
    wait_valid(20, cyc);
    checks++;
    if (bus.user_valid !== 4'b0001 || cyc !== 3) begin errors++; $display("FAIL t5_valid got %b after %0d want 0001 after 3", bus.user_valid, cyc); end
    checks++;
    if (bus.user_output !== enc(out_val)) begin errors++; $display("FAIL t5_output got %h want %h", bus.user_output, enc(out_val)); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.user_valid !== 4'b0000) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL t5_single_valid got %0d extra valid cycles want 0", bad); end
    $display("test_glitch done");
  endtask

  task automatic test_reset_mid;
    int cyc;
    int bad;
    bus.user_input[1] = enc(4'h5);
    bus.user_input[2] = enc(4'hC);
    bus.user_req = 4'b0010;
    wait_ack(10, cyc);
    checks++;
    if (bus.user_ack !== 4'b0010) begin errors++; $display("FAIL t6_ack got %b want 0010", bus.user_ack); end
    bus.user_req = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, bus.user_valid, bus.user_ack, bus.user_err, stray} !== '0) begin
      errors++;
      $display("FAIL t6_reset_flags got busy=%b valid=%b ack=%b err=%b stray=%b want 0", busy, bus.user_valid, bus.user_ack, bus.user_err, stray);
    end
    checks++;
    if (bus.in !== '0 || bus.user_output !== '0) begin errors++; $display("FAIL t6_reset_data got in=%h out=%h want 00 00", bus.in, bus.user_output); end
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.user_valid !== 4'b0000) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL t6_abandoned got %0d valid cycles want 0", bad); end
    // With the pointer back at 0, user1 beats user2.
    bus.user_req = 4'b0110;
    wait_ack(10, cyc);
    checks++;
    if (bus.user_ack !== 4'b0010) begin errors++; $display("FAIL t6_ptr_reset got %b want 0010", bus.user_ack); end
    checks++;
    if (bus.in !== enc(4'h5)) begin errors++; $display("FAIL t6_in got %h want %h", bus.in, enc(4'h5)); end
    bus.user_req = '0;
    flip_out();
    wait_valid(20, cyc);
    checks++;
    if (bus.user_valid !== 4'b0010 || cyc !== 3) begin errors++; $display("FAIL t6_valid got %b after %0d want 0010 after 3", bus.user_valid, cyc); end
    checks++;
    if (bus.user_output !== enc(out_val) || bus.user_err !== 1'b0) begin
      errors++;
      $display("FAIL t6_output got %h err=%b want %h err=0", bus.user_output, bus.user_err, enc(out_val));
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    out_val = '0;
    bus.out = enc(out_val);
    bus.user_req = '0;
    bus.user_input = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stray();
    test_glitch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
